// File: rtl/gpu_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gpu_cmd_ctrl_if
// Purpose  : Command stream, memory bus, cache strobes and status of the
//            GPU command sequencer, bundled as one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface gpu_cmd_ctrl_if #(
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  mem_ack;
  logic                  instr_we;
  logic                  spr_we;
  logic [CNT_WIDTH-1:0]  cache_idx;
  logic                  exec_en;
  logic                  busy;
  logic                  done;
  logic [3:0]            state;

  // master: the sequencer itself
  modport master (
    input  in_data, in_valid, mem_ack,
    output in_ready, mem_addr, mem_rd, mem_wr, instr_we, spr_we,
           cache_idx, exec_en, busy, done, state
  );

  // slave: the CPU port / memory / caches around it
  modport slave (
    output in_data, in_valid, mem_ack,
    input  in_ready, mem_addr, mem_rd, mem_wr, instr_we, spr_we,
           cache_idx, exec_en, busy, done, state
  );
endinterface
`default_nettype wire

// File: rtl/gpu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpu_cmd_ctrl
// Purpose  : GPU command sequencer: activation word, 4-word descriptor, then
//            instruction load, sprite load, execute, sprite write-back.
//            Optional macro GPU_CTRL_ABORT_EN enables abort by ~ACTIVATE.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_cmd_ctrl #(
  parameter int                IN_WIDTH   = 16,
  parameter int                ADDR_WIDTH = 16,
  parameter int                CNT_WIDTH  = 8,
  parameter logic [IN_WIDTH-1:0] ACTIVATE = 16'h0F0F
) (
  input  logic              clk,
  input  logic              rst_n,
  gpu_cmd_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_PRG_NINSTR = 4'd1,
    S_PRG_SPRW   = 4'd2,
    S_PRG_SRC    = 4'd3,
    S_PRG_DEST   = 4'd4,
    S_LD_INSTR   = 4'd5,
    S_LD_SPR     = 4'd6,
    S_EXEC       = 4'd7,
    S_WR_SPR     = 4'd8,
    S_DONE       = 4'd9
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_n;
  logic [CNT_WIDTH-1:0]  r_w;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  w_idx_next;
  logic [CNT_WIDTH:0]    w_idx_inc;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  r_rd;
  logic                  r_wr;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_abort;
  logic                  w_last_n;
  logic                  w_last_w;

  assign w_accept  = bus.in_valid & w_ready;
  assign w_ack     = bus.mem_ack & (r_rd | r_wr);
  assign w_idx_inc = {1'b0, r_idx} + (CNT_WIDTH+1)'(1);
  assign w_last_n  = (w_idx_inc == {1'b0, r_n});
  assign w_last_w  = (w_idx_inc == {1'b0, r_w});

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE, S_PRG_NINSTR, S_PRG_SPRW, S_PRG_SRC, S_PRG_DEST: w_ready = 1'b1;
`ifdef GPU_CTRL_ABORT_EN
      S_LD_INSTR, S_LD_SPR, S_EXEC, S_WR_SPR:                 w_ready = 1'b1;
`endif
      default:                                                w_ready = 1'b0;
    endcase
  end

`ifdef GPU_CTRL_ABORT_EN
  assign w_abort = w_accept && (bus.in_data == ~ACTIVATE) &&
                   ((r_state == S_LD_INSTR) || (r_state == S_LD_SPR) ||
                    (r_state == S_EXEC)     || (r_state == S_WR_SPR));
`else
  assign w_abort = 1'b0;
`endif

  // Next state and element index; every phase entry restarts the index at 0.
  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      S_IDLE:       if (w_accept && (bus.in_data == ACTIVATE)) w_next = S_PRG_NINSTR;
      S_PRG_NINSTR: if (w_accept) w_next = S_PRG_SPRW;
      S_PRG_SRC:    if (w_accept) w_next = S_PRG_DEST;
      S_PRG_SPRW:   if (w_accept) w_next = S_PRG_SRC;
      S_PRG_DEST: begin
        // EXEC needs N>0 and WR_SPR needs W>0, so the loads always come first.
        if (w_accept) begin
          w_idx_next = '0;
          w_next     = (r_n != '0) ? S_LD_INSTR : (r_w != '0) ? S_LD_SPR : S_DONE;
        end
      end
      S_LD_INSTR: begin
        if (w_ack) begin
          if (w_last_n) begin
            w_idx_next = '0;
            w_next     = (r_w != '0) ? S_LD_SPR : S_EXEC;
          end else begin
            w_idx_next = w_idx_inc[CNT_WIDTH-1:0];
          end
        end
      end
      S_LD_SPR: begin
        if (w_ack) begin
          if (w_last_w) begin
            w_idx_next = '0;
            w_next     = (r_n != '0) ? S_EXEC : S_WR_SPR;
          end else begin
            w_idx_next = w_idx_inc[CNT_WIDTH-1:0];
          end
        end
      end
      S_EXEC: begin
        if (w_last_n) begin
          w_idx_next = '0;
          w_next     = (r_w != '0) ? S_WR_SPR : S_DONE;
        end else begin
          w_idx_next = w_idx_inc[CNT_WIDTH-1:0];
        end
      end
      S_WR_SPR: begin
        if (w_ack) begin
          if (w_last_w) begin
            w_idx_next = '0;
            w_next     = S_DONE;
          end else begin
            w_idx_next = w_idx_inc[CNT_WIDTH-1:0];
          end
        end
      end
      S_DONE: w_next = S_IDLE;
      default: begin
        w_next     = S_IDLE;
        w_idx_next = '0;
      end
    endcase
    if (w_abort) begin
      w_next     = S_IDLE;
      w_idx_next = '0;
    end
  end

  always_comb begin
    w_addr_next = r_addr;
    case (w_next)
      S_LD_INSTR: w_addr_next = r_src + ADDR_WIDTH'(w_idx_next);
      S_LD_SPR:   w_addr_next = r_src + ADDR_WIDTH'(r_n) + ADDR_WIDTH'(w_idx_next);
      S_WR_SPR:   w_addr_next = r_dest + ADDR_WIDTH'(w_idx_next);
      default:    w_addr_next = r_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      r_addr  <= w_addr_next;
      r_rd    <= (w_next == S_LD_INSTR) || (w_next == S_LD_SPR);
      r_wr    <= (w_next == S_WR_SPR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n    <= '0;
      r_w    <= '0;
      r_src  <= '0;
      r_dest <= '0;
    end else if (w_accept) begin
      case (r_state)
        S_PRG_NINSTR: r_n    <= bus.in_data[CNT_WIDTH-1:0];
        S_PRG_SPRW:   r_w    <= bus.in_data[CNT_WIDTH-1:0];
        S_PRG_SRC:    r_src  <= bus.in_data[ADDR_WIDTH-1:0];
        S_PRG_DEST:   r_dest <= bus.in_data[ADDR_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_rd    = r_rd;
  assign bus.mem_wr    = r_wr;
  assign bus.instr_we  = r_rd & bus.mem_ack & (r_state == S_LD_INSTR);
  assign bus.spr_we    = r_rd & bus.mem_ack & (r_state == S_LD_SPR);
  assign bus.cache_idx = r_idx;
  assign bus.exec_en   = (r_state == S_EXEC);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_cmd_ctrl
// Purpose  : Randomized scoreboard bench for gpu_cmd_ctrl; each job's
//            expected transfer/exec/done sequence is queued and a monitor
//            compares what the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_cmd_ctrl;

  localparam int K_RDI  = 1;
  localparam int K_RDS  = 2;
  localparam int K_EXEC = 3;
  localparam int K_WR   = 4;
  localparam int K_DONE = 5;
  localparam int K_RDX  = 6;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    int          idx;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 0;
  int   cyc = 0;
  ev_t  exp_q[$];

  logic        p_pend = 1'b0;
  logic        p_rd;
  logic        p_wr;
  logic [15:0] p_addr;

  initial forever #5 clk = ~clk;

  gpu_cmd_ctrl_if #(.IN_WIDTH(16), .ADDR_WIDTH(16), .CNT_WIDTH(8)) bus ();

  gpu_cmd_ctrl #(
    .IN_WIDTH(16), .ADDR_WIDTH(16), .CNT_WIDTH(8), .ACTIVATE(16'h0F0F)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [15:0] addr, input int idx);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d addr=%h idx=%0d required=none", kind, addr, idx);
      return;
    end
    e = exp_q.pop_front();
    if (kind != e.kind || idx != e.idx ||
        ((kind == K_RDI || kind == K_RDS || kind == K_WR) && addr != e.addr)) begin
      errors++;
      $display("FAIL event actual kind=%0d addr=%h idx=%0d required kind=%0d addr=%h idx=%0d",
               kind, addr, idx, e.kind, e.addr, e.idx);
    end
  endtask

  // Reference: a job is N instruction reads, W sprite reads, N exec cycles,
  // W write-backs and a done pulse, in that order.
  task automatic expect_job(input int n, input int w, input logic [15:0] src, input logic [15:0] dest);
    for (int i = 0; i < n; i++) exp_q.push_back('{K_RDI, src + 16'(i), i});
    for (int j = 0; j < w; j++) exp_q.push_back('{K_RDS, src + 16'(n) + 16'(j), j});
    for (int i = 0; i < n; i++) exp_q.push_back('{K_EXEC, 16'h0, i});
    for (int j = 0; j < w; j++) exp_q.push_back('{K_WR, dest + 16'(j), j});
    exp_q.push_back('{K_DONE, 16'h0, 0});
  endtask

  // Memory acknowledge: always, every third cycle, or random.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ack_mode)
        0:       bus.mem_ack = 1'b1;
        1:       bus.mem_ack = (cyc % 3 == 0);
        default: bus.mem_ack = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_pend = 1'b0;
        continue;
      end
      if (p_pend)
        chk("req_hold", {14'h0, bus.mem_rd, bus.mem_wr, bus.mem_addr}, {14'h0, p_rd, p_wr, p_addr});
      p_pend = (bus.mem_rd | bus.mem_wr) & ~bus.mem_ack;
      p_rd   = bus.mem_rd;
      p_wr   = bus.mem_wr;
      p_addr = bus.mem_addr;
      if (bus.mem_rd && bus.mem_ack)
        observe(bus.instr_we ? K_RDI : (bus.spr_we ? K_RDS : K_RDX), bus.mem_addr, int'(bus.cache_idx));
      if (bus.mem_wr && bus.mem_ack) observe(K_WR, bus.mem_addr, int'(bus.cache_idx));
      if (bus.exec_en) observe(K_EXEC, 16'h0, int'(bus.cache_idx));
      if (bus.done) observe(K_DONE, 16'h0, 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accept", {31'h0, ok}, 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n, input int w, input logic [15:0] src, input logic [15:0] dest);
    expect_job(n, w, src, dest);
    send_word(16'h0F0F);
    chk("state_after_act", {28'h0, bus.state}, 32'd1);
    chk("busy_after_act", {31'h0, bus.busy}, 32'h1);
    send_word(16'(n));
    send_word(16'(w));
    send_word(src);
    send_word(dest);
  endtask

  task automatic run_job(input int n, input int w, input logic [15:0] src, input logic [15:0] dest, input int mode);
    bit fin;
    fin = 1'b0;
    ack_mode = mode;
    start_job(n, w, src, dest);
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && bus.state == 4'd0) fin = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("job_complete", {31'h0, fin}, 32'h1);
    if (!fin) do_reset();
  endtask

  task automatic wait_state(input logic [3:0] s);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (bus.state == s) hit = 1'b1;
    end
    chk("reach_state", {31'h0, hit}, 32'h1);
  endtask

  initial begin
    logic [15:0] d;
    bus.in_data  = 16'h0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", {28'h0, bus.state}, 32'h0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
    chk("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    chk("rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    chk("rst_instr_we", {31'h0, bus.instr_we}, 32'h0);
    chk("rst_spr_we", {31'h0, bus.spr_we}, 32'h0);
    chk("rst_cache_idx", {24'h0, bus.cache_idx}, 32'h0);
    chk("rst_exec_en", {31'h0, bus.exec_en}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_word(16'h1234);
    chk("ignore_state", {28'h0, bus.state}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      if (d == 16'h0F0F) d = 16'h0F0E;
      send_word(d);
      chk("ignore_busy", {31'h0, bus.busy}, 32'h0);
    end

    run_job(3, 2, 16'h0100, 16'h0200, 0);
    run_job(3, 2, 16'h0100, 16'h0200, 1);
    run_job(0, 0, 16'h1111, 16'h2222, 0);
    run_job(2, 0, 16'hFFFF, 16'h0300, 0);
    run_job(0, 3, 16'hFFFE, 16'hFFFF, 2);
    for (int k = 0; k < 8; k++)
      run_job($urandom_range(0, 6), $urandom_range(0, 4), 16'($urandom), 16'($urandom),
              $urandom_range(0, 2));

    ack_mode = 0;
    start_job(3, 2, 16'h0100, 16'h0200);
    wait_state(4'd8);
    #2;
    chk("wr_before_rst", {31'h0, bus.mem_wr}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    chk("rst_mid_state", {28'h0, bus.state}, 32'h0);
    chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef GPU_CTRL_ABORT_EN
    start_job(4, 0, 16'h0400, 16'h0500);
    wait_state(4'd7);
    @(posedge clk);
    #1;
    send_word(16'hF0F0);
    chk("abort_state", {28'h0, bus.state}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
`endif

    run_job(1, 1, 16'h7FFF, 16'h8000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpu_cmd_ctrl.md
# gpu_cmd_ctrl

Parametrised GPU command sequencer sitting between the CPU command port and the GPU instruction/sprite caches and memory bus. It detects the activation word, captures a four-word job descriptor over a valid/ready stream, then runs the job:

- fetch N instructions into the instruction cache
- fetch a W-word sprite into the sprite cache
- execute for N cycles
- write the W-word sprite back to memory

All counts, widths and addresses are parameters; zero-length phases are skipped.

## Interface
Parameters:
- IN_WIDTH, 16, command stream word width
- ADDR_WIDTH, 16, memory address width (must be ≤ IN_WIDTH)
- CNT_WIDTH, 8, instruction/sprite count width (must be ≤ IN_WIDTH)
- ACTIVATE, 16'h0F0F, activation word, compared over IN_WIDTH bits

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  IN_WIDTH  command word
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts in_data this cycle
- mem_addr  out  ADDR_WIDTH  memory address, registered
- mem_rd  out  1  read request, registered, held until mem_ack
- mem_wr  out  1  write request, registered, held until mem_ack
- mem_ack  in  1  memory completes the current request this cycle
- instr_we  out  1  instruction-cache write strobe = mem_rd & mem_ack in LD_INSTR
- spr_we  out  1  sprite-cache write strobe = mem_rd & mem_ack in LD_SPR
- cache_idx  out  CNT_WIDTH  current element index for cache read/write
- exec_en  out  1  execute-unit enable, high in EXEC
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- state  out  4  current state encoding

## Operation
- States and encoding: IDLE=0, PRG_NINSTR=1, PRG_SPRW=2, PRG_SRC=3, PRG_DEST=4, LD_INSTR=5, LD_SPR=6, EXEC=7, WR_SPR=8, DONE=9. Unused encodings go to IDLE.
- Accept = in_valid & in_ready. in_ready=1 in IDLE and PRG_*; 0 elsewhere (see Configuration).
- IDLE: on an accepted word equal to ACTIVATE, go to PRG_NINSTR. Any other accepted word is consumed and ignored.
- PRG_NINSTR/PRG_SPRW/PRG_SRC/PRG_DEST: each accepted word latches N (low CNT_WIDTH bits), W (low CNT_WIDTH bits), SRC and DEST (low ADDR_WIDTH bits) in turn, then advances. Without an accepted word the state holds.
- After PRG_DEST, the next state is the first non-empty phase, in order: LD_INSTR if N>0, LD_SPR if W>0, EXEC if N>0, WR_SPR if W>0, else DONE.
- LD_INSTR: reads SRC+i for i=0..N-1.
- LD_SPR: reads SRC+N+j for j=0..W-1.
- WR_SPR: writes DEST+j for j=0..W-1.
- In each memory phase the request is held with a stable address until mem_ack. On ack the index increments and the next request is issued the following cycle. On the last ack the block moves to the next phase.
- EXEC: exec_en=1 for exactly N cycles; cache_idx counts 0..N-1.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently). Count arithmetic uses CNT_WIDTH+1 bits internally, so N=2^CNT_WIDTH-1 does not overflow.

## Timing
- Reset values: state=IDLE, in_ready=1, mem_rd=0, mem_wr=0, mem_addr=0, instr_we=0, spr_we=0, cache_idx=0, exec_en=0, busy=0, done=0. Latched N/W/SRC/DEST are all 0.
- Reset asserted mid-job: all outputs return to reset values immediately (asynchronous), and the job is dropped.
- Activation word accepted at edge k: state=PRG_NINSTR after edge k. Back-to-back descriptor words need 4 further edges.
- Memory phase: state entered at edge t, mem_rd/mem_wr=1 from t. With mem_ack high continuously, one element transfers per cycle: ack at cycle t+i transfers element i.
- mem_ack sampled while mem_rd=mem_wr=0 is ignored.
- Minimum job (N=W=0): activate plus 4 words, then DONE for 1 cycle, then IDLE.

## Configuration
- GPU_CTRL_ABORT_EN defined:
  - in_ready=1 in LD_INSTR, LD_SPR, EXEC and WR_SPR.
  - An accepted word equal to ~ACTIVATE drops any outstanding request and moves to IDLE at the next edge, with no done pulse. Other words accepted in these states are ignored.
  - If abort and mem_ack coincide, the abort wins, but the strobe for that cycle's ack still fires.
- GPU_CTRL_ABORT_EN undefined: in_ready=0 in those four states and jobs always run to completion.

## Test plan
- Reset then stream 16'h1234, 16'h0F0F: 16'h1234 is ignored and state=1 after the second accept; busy=1.
- Descriptor N=3, W=2, SRC=16'h0100, DEST=16'h0200, mem_ack tied high:
  - reads at 0x0100–0x0102 with instr_we ×3, then 0x0103–0x0104 with spr_we ×2
  - exec_en high for 3 cycles
  - writes at 0x0200–0x0201
  - single done pulse, then IDLE
- Same job with mem_ack asserted every third cycle: address and mem_rd stay stable between acks; strobe count is still 3+2 and the write count 2.
- N=0, W=0: goes PRG_DEST→DONE→IDLE; mem_rd, mem_wr and exec_en never assert.
- SRC=16'hFFFF, N=2, W=0: reads at 0xFFFF then 0x0000.
- rst_n pulled low during WR_SPR: mem_wr=0 and state=0 without waiting for a clock edge. With GPU_CTRL_ABORT_EN, sending 16'hF0F0 in EXEC returns to IDLE next edge with done=0.
